// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures one word on load, then shifts it out
// one bit per clock (optionally followed by an even-parity bit), with registered outputs.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             done
);

  localparam int N  = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] PARIDX = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             par, par_next;
  logic             bit_next;

  // Every output is a flop loaded from the same next-state decisions as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      ready     <= 1'b1;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      cnt       <= cnt_next;
      par       <= par_next;
      ready     <= (state_next == IDLE);
      sdo       <= bit_next;
      sdo_valid <= (state_next == SHIFT);
      done      <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt is the index of the bit currently on sdo; bit_next is the bit for the next cycle.
  always_comb begin
    sreg_next = sreg;
    cnt_next  = cnt;
    par_next  = par;
    bit_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sreg_next = din;
          cnt_next  = '0;
          par_next  = ^din;
          bit_next  = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_next  = cnt + CW'(1);
          sreg_next = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
          if ((PARITY != 0) && (cnt_next == PARIDX))
            bit_next = par;
          else
            bit_next = (LSB_FIRST != 0) ? sreg[1] : sreg[WIDTH-2];
        end
      end
      default: ;
    endcase
  end

endmodule
